// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a
// fixed, parameterised response latency and a valid/ready handshake
// on both the request and response sides.
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to also report an
// error for byte addresses that are not doubleword aligned. Without
// it, addr[2:0] is ignored and only the range check applies.

module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] element1,
  output logic [63:0] element2,
  output logic [63:0] element3,
  output logic [63:0] element4,
  output logic [63:0] element5,
  output logic [63:0] element6,
  output logic [63:0] element7,
  output logic [63:0] element8
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAT = 4'(LATENCY);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  logic [1:0]    state;
  logic [3:0]    count;
  logic          cap_write;
  logic [63:0]   cap_addr;
  logic [63:0]   cap_wdata;
  logic [63:0]   mem [DEPTH];

  logic          handshake;
  logic          op_write;
  logic [63:0]   op_addr;
  logic [63:0]   op_wdata;
  logic [60:0]   op_index;
  logic [AW-1:0] word_sel;
  logic          range_err;
  logic          misalign;
  logic          op_err;
  logic          enter_resp;

  assign req_ready = (state == IDLE);
  assign handshake = req_valid & req_ready;

  // With zero latency the access happens on the accept edge itself, so
  // the operation comes straight from the request ports while idle and
  // from the captured copy otherwise.
  always_comb begin
    op_write = cap_write;
    op_addr  = cap_addr;
    op_wdata = cap_wdata;
    if (state == IDLE) begin
      op_write = req_write;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
  end

  assign op_index   = op_addr[63:3];
  assign word_sel   = op_index[AW-1:0];
  assign range_err  = (op_index >= 61'(DEPTH));
  assign misalign   = |op_addr[2:0];
  assign op_err     = range_err | (MISALIGN_EN & misalign);

  assign enter_resp = ((state == IDLE) && handshake && (LAT == 4'd0)) ||
                      ((state == WAIT) && (count == 4'd1));

  // Request FSM: accept in IDLE, count down the latency in WAIT, and
  // hold the response in RESP until the initiator takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= 64'd0;
      cap_wdata <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            if (LAT == 4'd0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= LAT;
            end
          end
        end
        WAIT: begin
          if (count == 4'd1) begin
            state <= RESP;
            count <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response registers are loaded once on the edge entering RESP and
  // then held untouched until the response is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 64'd0;
    end else if (enter_resp) begin
      rsp_valid <= 1'b1;
      rsp_err   <= op_err;
      rsp_rdata <= (!op_write && !op_err) ? mem[word_sel] : 64'd0;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 64'd0;
    end
  end

  // Storage commits a good store on the edge entering RESP; errored
  // stores and anything aborted by reset never reach the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 64'd0;
      end
    end else if (enter_resp && op_write && !op_err) begin
      mem[word_sel] <= op_wdata;
    end
  end

  assign element1 = mem[0];
  assign element2 = mem[1];
  assign element3 = mem[2];
  assign element4 = mem[3];
  assign element5 = mem[4];
  assign element6 = mem[5];
  assign element7 = mem[6];
  assign element8 = mem[7];

endmodule
